// File: rtl/dtcm_arb_pkg.sv
// Shared types for the DTCM arbiter: FSM state encoding and starvation counter width.
package dtcm_arb_pkg;
  localparam int STARVE_W = 4;

  typedef enum logic {
    ARB_CPU   = 1'b0,
    ARB_FORCE = 1'b1
  } arb_state_t;
endpackage

// File: rtl/dtcm_arbiter_starve_cnt.sv
// Counts consecutive ungranted DMA request cycles (saturating) and flags the cycle
// that pushes the count past STARVE_MAX-1, arming a forced grant for the next cycle.
module arb_starve_cnt
  import dtcm_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic thresh_hit
);

  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!dma_req || dma_gnt) begin
      cnt_d = '0;
    end else if (cnt_q != {STARVE_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
    thresh_hit = dma_req && !dma_gnt && (cnt_q == STARVE_W'(STARVE_MAX - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dtcm_arbiter.sv
// Two-port DTCM arbiter: CPU has priority, DMA wins idle cycles and is force-granted
// for one cycle after STARVE_MAX ungranted request cycles; read data returns one cycle later.
module dtcm_arbiter
  import dtcm_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [3:0]  dma_be,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_t state_q, state_d;
  logic       sel_dma_q, sel_dma_d;
  logic       rd_q, rd_d;
  logic       dma_own;
  logic       cpu_own;
  logic       thresh_hit;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk        (clk),
    .reset      (reset),
    .dma_req    (dma_req),
    .dma_gnt    (dma_own),
    .thresh_hit (thresh_hit)
  );

  always_comb begin
    dma_own   = 1'b0;
    cpu_own   = 1'b0;
    mem_addr  = cpu_addr;
    mem_wen   = 4'h0;
    mem_wdata = cpu_wdata;
    state_d   = ARB_CPU;

    // Nobody owns the array while reset is held, so no grant can leak out of reset.
    if (!reset) begin
      if (state_q == ARB_FORCE && dma_req) begin
        dma_own = 1'b1;
      end else if (cpu_en) begin
        cpu_own = 1'b1;
      end else if (dma_req) begin
        dma_own = 1'b1;
      end
    end

    if (dma_own) begin
      mem_addr  = dma_addr;
      mem_wen   = dma_we ? dma_be : 4'h0;
      mem_wdata = dma_wdata;
    end else if (cpu_own) begin
      mem_addr  = cpu_addr;
      mem_wen   = cpu_wen;
      mem_wdata = cpu_wdata;
    end

    // ARB_FORCE lasts exactly one cycle regardless of whether DMA still asks.
    if (state_q == ARB_CPU && thresh_hit) begin
      state_d = ARB_FORCE;
    end

    sel_dma_d = dma_own;
    rd_d      = dma_own ? !dma_we : (cpu_own && (cpu_wen == 4'h0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_CPU;
      sel_dma_q <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_dma_q <= sel_dma_d;
      rd_q      <= rd_d;
    end
  end

  assign dma_gnt    = dma_own;
  assign cpu_stall  = cpu_en && dma_own;
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign dma_rvalid = sel_dma_q && rd_q;

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Randomised and directed bench for dtcm_arbiter against a cycle-level reference model.
module tb_dtcm_arbiter;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic [3:0]  dma_be;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dtcm_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // DTCM behavioural memory: byte writes, registered read.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_wen[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    mem_rdata <= mem[mem_addr[9:2]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: consecutive ungranted DMA cycles, expected memory, pending reads.
  int          waited;
  logic [31:0] ref_mem [0:255];
  bit          pend_dma_rd;
  bit          pend_cpu_rd;
  logic [31:0] pend_data;

  task automatic set_cpu(input bit en, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] data);
    cpu_en = en; cpu_wen = wen; cpu_addr = addr; cpu_wdata = data;
  endtask

  task automatic set_dma(input bit req, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] data);
    dma_req = req; dma_we = we; dma_be = be; dma_addr = addr; dma_wdata = data;
  endtask

  function automatic bit model_dma_own();
    return dma_req && (!cpu_en || waited >= STARVE_MAX);
  endfunction

  function automatic logic [35:0] model_mem_port();
    bit d;
    d = model_dma_own();
    if (d) return {(dma_we ? dma_be : 4'h0), dma_addr};
    if (cpu_en) return {cpu_wen, cpu_addr};
    return {4'h0, cpu_addr};
  endfunction

  // Advance one clock, updating the model with this cycle's expected outcome.
  task automatic tick();
    bit d, c, nd, nc;
    int ia;
    logic [31:0] rd;
    d  = model_dma_own();
    c  = cpu_en && !d;
    ia = d ? int'(dma_addr[9:2]) : int'(cpu_addr[9:2]);
    rd = ref_mem[ia];
    nd = d && !dma_we;
    nc = c && (cpu_wen == 4'h0);
    for (int b = 0; b < 4; b++) begin
      if (d && dma_we && dma_be[b]) ref_mem[ia][b*8 +: 8] = dma_wdata[b*8 +: 8];
      if (c && cpu_wen[b]) ref_mem[ia][b*8 +: 8] = cpu_wdata[b*8 +: 8];
    end
    waited = (dma_req && !d) ? waited + 1 : 0;
    @(posedge clk);
    #1;
    pend_dma_rd = nd;
    pend_cpu_rd = nc;
    pend_data   = rd;
  endtask

  task automatic model_reset();
    waited = 0; pend_dma_rd = 0; pend_cpu_rd = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_cpu(0, 4'h0, 32'h0, 32'h0);
    set_dma(0, 0, 4'h0, 32'h0, 32'h0);
    model_reset();
    #2;
    n_checks++;
    if ({dma_rvalid, dma_gnt, cpu_stall, mem_wen} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_idle: rvalid/gnt/stall/wen=%b required 0", {dma_rvalid, dma_gnt, cpu_stall, mem_wen});
    end
    set_cpu(1, 4'h0, 32'h8, 32'h0);
    set_dma(1, 0, 4'h0, 32'h100, 32'h0);
    #1;
    n_checks++;
    if ({dma_gnt, cpu_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_no_grant: gnt/stall=%b required 00", {dma_gnt, cpu_stall});
    end
    set_cpu(0, 4'h0, 32'h0, 32'h0);
    set_dma(0, 0, 4'h0, 32'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    n_checks++;
    if (dma_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rvalid_after: got %b required 0", dma_rvalid);
    end
  endtask

  task automatic test_dma_only();
    set_dma(1, 1, 4'hF, 32'h100, 32'hDEADBEEF);
    #1;
    n_checks++;
    if ({dma_gnt, mem_wen, mem_addr, mem_wdata} !== {1'b1, 4'hF, 32'h100, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL dma_write: gnt=%b wen=%h addr=%h wdata=%h required 1 f 100 deadbeef",
               dma_gnt, mem_wen, mem_addr, mem_wdata);
    end
    tick();
    set_dma(1, 0, 4'h0, 32'h100, 32'h0);
    #1;
    n_checks++;
    if ({dma_gnt, mem_wen, dma_rvalid} !== {1'b1, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL dma_read_grant: gnt=%b wen=%h rvalid=%b required 1 0 0", dma_gnt, mem_wen, dma_rvalid);
    end
    tick();
    set_dma(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    n_checks++;
    if ({dma_rvalid, dma_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL dma_read_data: rvalid=%b rdata=%h required 1 deadbeef", dma_rvalid, dma_rdata);
    end
    tick();
    n_checks++;
    if (dma_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL dma_rvalid_single: got %b required 0", dma_rvalid);
    end
  endtask

  task automatic test_cpu_only();
    for (int i = 0; i < 24; i++) begin
      set_cpu(1, ($urandom % 2) ? 4'($urandom) : 4'h0, {22'h0, 8'($urandom % 16), 2'b00}, $urandom);
      #1;
      n_checks++;
      if ({cpu_stall, mem_wen, mem_addr} !== {1'b0, cpu_wen, cpu_addr}) begin
        n_fail++;
        $display("FAIL cpu_only_port[%0d]: stall=%b wen=%h addr=%h required 0 %h %h",
                 i, cpu_stall, mem_wen, mem_addr, cpu_wen, cpu_addr);
      end
      tick();
      if (pend_cpu_rd) begin
        n_checks++;
        if (cpu_rdata !== pend_data) begin
          n_fail++;
          $display("FAIL cpu_only_rdata[%0d]: got %h required %h", i, cpu_rdata, pend_data);
        end
      end
    end
    set_cpu(0, 4'h0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_contention();
    set_dma(1, 0, 4'h0, 32'h100, 32'h0);
    for (int i = 0; i < 15; i++) begin
      set_cpu(1, 4'h0, 32'h80 + 32'(i * 4), 32'h0);
      #1;
      n_checks++;
      if ({dma_gnt, cpu_stall} !== {2{(i % 5) == 4}}) begin
        n_fail++;
        $display("FAIL contention_gnt[%0d]: gnt/stall=%b required %b", i, {dma_gnt, cpu_stall}, {2{(i % 5) == 4}});
      end
      tick();
      n_checks++;
      if ({dma_rvalid, (dma_rvalid ? dma_rdata : 32'h0)} !==
          {((i % 5) == 4), (((i % 5) == 4) ? 32'hDEADBEEF : 32'h0)}) begin
        n_fail++;
        $display("FAIL contention_rvalid[%0d]: rvalid=%b rdata=%h", i, dma_rvalid, dma_rdata);
      end
    end
    set_cpu(0, 4'h0, 32'h0, 32'h0);
    set_dma(0, 0, 4'h0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_collision();
    set_dma(1, 1, 4'hF, 32'h40, 32'h22);
    for (int i = 0; i < 4; i++) begin
      set_cpu(1, 4'h0, 32'h80, 32'h0);
      tick();
    end
    set_cpu(1, 4'hF, 32'h40, 32'h11);
    #1;
    n_checks++;
    if ({dma_gnt, cpu_stall, mem_wen, mem_wdata} !== {1'b1, 1'b1, 4'hF, 32'h22}) begin
      n_fail++;
      $display("FAIL collision_force: gnt=%b stall=%b wen=%h wdata=%h required 1 1 f 22",
               dma_gnt, cpu_stall, mem_wen, mem_wdata);
    end
    tick();
    n_checks++;
    if (mem[16] !== 32'h22) begin
      n_fail++;
      $display("FAIL collision_dma_first: mem=%h required 22", mem[16]);
    end
    set_dma(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    n_checks++;
    if ({dma_gnt, cpu_stall, mem_wen, mem_wdata} !== {1'b0, 1'b0, 4'hF, 32'h11}) begin
      n_fail++;
      $display("FAIL collision_cpu_next: gnt=%b stall=%b wen=%h wdata=%h required 0 0 f 11",
               dma_gnt, cpu_stall, mem_wen, mem_wdata);
    end
    tick();
    set_cpu(0, 4'h0, 32'h0, 32'h0);
    set_dma(1, 0, 4'h0, 32'h40, 32'h0);
    tick();
    set_dma(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    n_checks++;
    if ({dma_rvalid, dma_rdata} !== {1'b1, 32'h11}) begin
      n_fail++;
      $display("FAIL collision_final: rvalid=%b rdata=%h required 1 11", dma_rvalid, dma_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    set_dma(1, 0, 4'h0, 32'h100, 32'h0);
    tick();
    reset = 1'b1;
    set_cpu(1, 4'h0, 32'h80, 32'h0);
    #1;
    n_checks++;
    if ({dma_rvalid, dma_gnt, cpu_stall} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_read: rvalid/gnt/stall=%b required 000", {dma_rvalid, dma_gnt, cpu_stall});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({dma_rvalid, dma_gnt} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_held: rvalid/gnt=%b required 00", {dma_rvalid, dma_gnt});
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (dma_gnt !== (i == 4)) begin
        n_fail++;
        $display("FAIL reset_counter_clear[%0d]: gnt=%b required %b", i, dma_gnt, (i == 4));
      end
      tick();
    end
    set_cpu(0, 4'h0, 32'h0, 32'h0);
    set_dma(0, 0, 4'h0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_force_drop();
    set_cpu(1, 4'h0, 32'h84, 32'h0);
    set_dma(1, 0, 4'h0, 32'h100, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    set_dma(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    n_checks++;
    if ({dma_gnt, cpu_stall, mem_wen} !== 6'b0) begin
      n_fail++;
      $display("FAIL force_drop: gnt/stall/wen=%b required 0", {dma_gnt, cpu_stall, mem_wen});
    end
    tick();
    set_dma(1, 0, 4'h0, 32'h100, 32'h0);
    for (int j = 0; j < 5; j++) begin
      #1;
      n_checks++;
      if (dma_gnt !== (j == 4)) begin
        n_fail++;
        $display("FAIL force_drop_recover[%0d]: gnt=%b required %b", j, dma_gnt, (j == 4));
      end
      tick();
    end
    set_cpu(0, 4'h0, 32'h0, 32'h0);
    set_dma(0, 0, 4'h0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_random();
    bit d;
    logic [35:0] port;
    for (int i = 0; i < 300; i++) begin
      if (!(cpu_en && cpu_stall)) begin
        set_cpu(($urandom % 4) != 0, ($urandom % 2) ? 4'($urandom) : 4'h0,
                {22'h0, 8'($urandom % 16), 2'b00}, $urandom);
      end
      if (!dma_req && ($urandom % 3) == 0) begin
        set_dma(1, $urandom % 2, 4'($urandom), {22'h0, 8'($urandom % 16), 2'b00}, $urandom);
      end
      #1;
      d    = model_dma_own();
      port = model_mem_port();
      n_checks++;
      if ({dma_gnt, cpu_stall, mem_wen, mem_addr} !== {d, (cpu_en && d), port}) begin
        n_fail++;
        $display("FAIL random_port[%0d]: gnt=%b stall=%b wen=%h addr=%h required %b %b %h",
                 i, dma_gnt, cpu_stall, mem_wen, mem_addr, d, (cpu_en && d), port);
      end
      tick();
      if (d) dma_req = 1'b0;
      n_checks++;
      if (dma_rvalid !== pend_dma_rd ||
          (pend_dma_rd && dma_rdata !== pend_data) ||
          (pend_cpu_rd && cpu_rdata !== pend_data)) begin
        n_fail++;
        $display("FAIL random_rdata[%0d]: rvalid=%b dma_rdata=%h cpu_rdata=%h required rvalid=%b data=%h",
                 i, dma_rvalid, dma_rdata, cpu_rdata, pend_dma_rd, pend_data);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem[k]     = 32'h0;
      ref_mem[k] = 32'h0;
    end
    test_reset();
    test_dma_only();
    test_cpu_only();
    test_contention();
    test_collision();
    test_reset_mid_read();
    test_force_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
